tristate_bus_arbiter: RTL and testbench

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

---
 rtl/tristate_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared 4-requester tri-state bus.
// Every owner change inserts TURNAROUND all-enables-low cycles, so two
// buffers never drive the bus together. A requester holding the bus while
// others wait is forced off after MAX_HOLD cycles. All outputs are
// registered, so there is no combinational path from req to any output.
module tristate_bus_arbiter #(
    parameter int unsigned MAX_HOLD   = 8,  // 1..255
    parameter int unsigned TURNAROUND = 1   // 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [3:0] enable,
    output logic [1:0] owner,
    output logic       bus_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] owner_q, owner_d;
    logic       busy_q, busy_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] turn_q, turn_d;

    logic       rr_found;
    logic [1:0] rr_winner;
    logic [1:0] rr_cand;
    logic       owner_released;
    logic       others_pending;
    logic       hold_done;

    // Round-robin search starting one past the current/most recent owner.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = owner_q;
        rr_cand   = owner_q;
        for (int k = 1; k <= 4; k++) begin
            rr_cand = owner_q + 2'(k);
            if (!rr_found && req[rr_cand]) begin
                rr_found  = 1'b1;
                rr_winner = rr_cand;
            end
        end
    end

    assign owner_released = ~req[owner_q];
    assign others_pending = |(req & ~gnt_q);
    assign hold_done      = (hold_q == HOLD_MAX);

    // Next-state, grant and counter logic for the IDLE/GRANT/TURN machine.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        turn_d  = turn_q;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (rr_found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << rr_winner;
                    owner_d = rr_winner;
                    hold_d  = 8'd1;
                end
            end

            GRANT: begin
                if (owner_released || (hold_done && others_pending)) begin
                    // Drop the bus now; the new owner waits out the turnaround.
                    state_d = TURN;
                    gnt_d   = '0;
                    hold_d  = '0;
                    turn_d  = TURN_LOAD;
                end else if (!hold_done) begin
                    hold_d = hold_q + 8'd1;
                end
            end

            TURN: begin
                gnt_d = '0;
                if (turn_q <= 4'd1) begin
                    // Last quiet cycle: the winner drives from the next cycle.
                    turn_d = '0;
                    if (rr_found) begin
                        state_d = GRANT;
                        gnt_d   = 4'b0001 << rr_winner;
                        owner_d = rr_winner;
                        hold_d  = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_d = turn_q - 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = |gnt_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= 2'd3;  // gives requester 0 first priority after reset
            busy_q  <= 1'b0;
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
        end
    end

    assign gnt      = gnt_q;
    assign enable   = gnt_q;
    assign owner    = owner_q;
    assign bus_busy = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: three instances with different
// MAX_HOLD/TURNAROUND share one req/reset stream and are compared every
// cycle against a behavioural model of owner, hold time and gap length.
module tb_tristate_bus_arbiter;

    localparam int NI = 3;

    function automatic int mh_of(input int g);
        case (g)
            0:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int ta_of(input int g);
        case (g)
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;

    logic [3:0] gnt_w  [NI];
    logic [3:0] en_w   [NI];
    logic [1:0] own_w  [NI];
    logic       busy_w [NI];

    int n_total = 0;
    int n_pass  = 0;

    // Model: current owner (-1 = none), cycles held, quiet cycles left, last owner.
    int m_own  [NI] = '{-1, -1, -1};
    int m_held [NI] = '{0, 0, 0};
    int m_gap  [NI] = '{0, 0, 0};
    int m_last [NI] = '{3, 3, 3};
    logic started = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        tristate_bus_arbiter #(
            .MAX_HOLD  (mh_of(g)),
            .TURNAROUND(ta_of(g))
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (req),
            .gnt     (gnt_w[g]),
            .enable  (en_w[g]),
            .owner   (own_w[g]),
            .bus_busy(busy_w[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_then(input logic [3:0] r);
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        rst_n = 1'b1;
        req   = r;
    endtask

    // Behavioural model: advance each instance by one clock.
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            int o, h, gp, l;
            o  = m_own[g];
            h  = m_held[g];
            gp = m_gap[g];
            l  = m_last[g];
            if (!rst_n) begin
                o = -1; h = 0; gp = 0; l = 3;
            end else if (o >= 0) begin
                if (!req[o] || (h >= mh_of(g) && (req & ~(4'b0001 << o)) != 4'b0000)) begin
                    o = -1; h = 0; gp = ta_of(g);
                end else if (h < mh_of(g)) begin
                    h = h + 1;
                end
            end else if (gp > 1) begin
                gp = gp - 1;
            end else begin
                gp = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (o < 0 && req[(l + k) % 4]) begin
                        o = (l + k) % 4;
                        h = 1;
                    end
                end
                if (o >= 0) l = o;
            end
            m_own[g]  <= o;
            m_held[g] <= h;
            m_gap[g]  <= gp;
            m_last[g] <= l;
        end
        if (!rst_n) started <= 1'b1;
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int g = 0; g < NI; g++) begin
                logic [3:0] e;
                e = (m_own[g] >= 0) ? (4'b0001 << m_own[g]) : 4'b0000;
                check($sformatf("gnt[%0d]", g), gnt_w[g], e);
                check($sformatf("enable[%0d]", g), en_w[g], e);
                check($sformatf("bus_busy[%0d]", g), busy_w[g], (e != 4'b0000));
                check($sformatf("owner[%0d]", g), own_w[g], m_last[g][1:0]);
                check($sformatf("onehot[%0d]", g), ($countones(en_w[g]) <= 1), 1'b1);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        tick();
        check("reset gnt", gnt_w[0], 4'b0000);
        check("reset busy", busy_w[0], 1'b0);
        check("reset owner", own_w[0], 2'd3);

        // Two requesters, MAX_HOLD=8: 8 cycles to req0, one gap, then req2.
        rst_n = 1'b1;
        req   = 4'b0101;
        tick();
        check("hold first", gnt_w[0], 4'b0001);
        repeat (7) begin
            tick();
            check("hold run", gnt_w[0], 4'b0001);
        end
        tick();
        check("hold gap", gnt_w[0], 4'b0000);
        tick();
        check("hold next", gnt_w[0], 4'b0100);
        check("hold next owner", own_w[0], 2'd2);

        // Release after three cycles; owner stays 1 through the idle return.
        reset_then(4'b0010);
        repeat (3) begin
            tick();
            check("release gnt", gnt_w[0], 4'b0010);
        end
        req = 4'b0000;
        tick();
        check("release drop", gnt_w[0], 4'b0000);
        check("release busy", busy_w[0], 1'b0);
        tick();
        check("release idle", gnt_w[0], 4'b0000);
        check("release owner", own_w[0], 2'd1);

        // All requesting, MAX_HOLD=2, TURNAROUND=1: 2 on / 1 off, order 0,1,2,3.
        reset_then(4'b1111);
        for (int t = 0; t < 40; t++) begin
            logic [3:0] e;
            tick();
            e = ((t % 3) == 2) ? 4'b0000 : (4'b0001 << ((t / 3) % 4));
            check("rr order", gnt_w[2], e);
        end

        // Lone requester keeps the bus with no timeout release.
        reset_then(4'b1000);
        repeat (20) begin
            tick();
            check("lone mh8", gnt_w[0], 4'b1000);
            check("lone mh2", gnt_w[1], 4'b1000);
        end

        // Reset mid-grant drops enable at once; re-grant after release of reset.
        reset_then(4'b0100);
        tick();
        check("midrst pre", gnt_w[0], 4'b0100);
        rst_n = 1'b0;
        tick();
        check("midrst enable", en_w[0], 4'b0000);
        check("midrst owner", own_w[0], 2'd3);
        rst_n = 1'b1;
        tick();
        check("midrst regrant", gnt_w[0], 4'b0100);

        // TURNAROUND=3: three quiet cycles, then req2 granted.
        reset_then(4'b0010);
        tick();
        check("ta3 pre", gnt_w[1], 4'b0010);
        req = 4'b0100;
        repeat (3) begin
            tick();
            check("ta3 quiet", en_w[1], 4'b0000);
        end
        tick();
        check("ta3 grant", gnt_w[1], 4'b0100);

        // Randomised traffic with occasional reset.
        repeat (3000) begin
            tick();
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
        end
        rst_n = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
